buffer_interconnect_v6: RTL and testbench
=========================================

// Module: buffer_interconnect_v6
// PURPOSE
//  Pipelined, parametrised crossbar between FHE compute modules and buffer-RAM slots: forward path (module -> slot, BufferRAMTEFsizeInputs)
//  and return path (slot read data -> module). Successor to the v5 interconnect: configurable register spacing in the mux trees,
//  double-buffered routing config with glitch-free drained commit, and a stall output so modules never see mixed-route traffic.
// PARAMETERS
//  SLOT_N     SLOT_NUM    number of buffer-RAM slots (>=2)
//  MOD_N      MODULE_NUM  number of compute modules (>=2)
//  DW         E*FSIZE     data width of wdata / read data
//  AW         32          raddr/waddr width
//  REG_EVERY  1           pipeline register after every REG_EVERY mux levels (1 = every level)
//  RAM_LAT    2           slot RAM read latency in cycles, used for drain count only
//  localparams: LM=$clog2(MOD_N), LS=$clog2(SLOT_N), LAT_F=ceil(LM/REG_EVERY), LAT_R=ceil(LS/REG_EVERY), DRAIN=LAT_F+RAM_LAT+LAT_R
// PORTS
//  clk               in   1                clock
//  rstn              in   1                async active-low reset
//  module_outputs    in   MOD_N x struct   per-module {raddr,waddr,wdata,wren} requests
//  ram_inputs        out  SLOT_N x struct  per-slot routed request
//  ram_outputs       in   SLOT_N x DW      per-slot read data
//  module_inputs     out  MOD_N x DW       per-module routed read data
//  cfg_module_sel    in   SLOT_N x LM      shadow: source module for each slot
//  cfg_slot_sel      in   MOD_N x LS       shadow: source slot for each module
//  cfg_wr            in   1                load both cfg_* vectors into shadow registers
//  cfg_commit        in   1                request shadow -> active swap
//  cfg_busy          out  1                high during DRAIN/SWAP
//  intc_stall        out  1                =cfg_busy; modules must hold requests
//  cfg_err           out  1                sticky config error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all pipe regs, ram_inputs, module_inputs = 0; active and shadow selects = 0; FSM=RUN; cfg_busy=0; cfg_err=0.
//  - Forward latency exactly LAT_F cycles, return latency exactly LAT_R cycles; selects travel with data (per-level select regs),
//    so each level uses the select of the request it carries. Out-of-range index or non-power-of-2 padding leg routes all-zero.
//  - One module may feed several slots (broadcast); one slot may feed several modules.
//  - FSM RUN: cfg_commit -> DRAIN, counter loaded with DRAIN-1. While DRAIN/SWAP, wren at tree inputs forced 0, raddr still passes.
//  - DRAIN: counter decrements each cycle; at 0 -> SWAP. SWAP (1 cycle): active <= shadow; -> RUN; cfg_busy falls next cycle.
//  - cfg_commit while busy: ignored (no queuing). cfg_wr any time: shadow updated; a write in the SWAP cycle is what is copied.
//  - cfg_wr and cfg_commit same cycle in RUN: new shadow value is committed.
//  - Async reset mid-DRAIN: everything returns to reset state; pending commit lost.
// CONFIGURATION
//  BUF_INTC_CFG_CHECK_EN defined: in SWAP, if any shadow cfg_module_sel>=MOD_N or cfg_slot_sel>=SLOT_N, the swap is refused
//   (active config unchanged), cfg_err set sticky until reset; FSM still -> RUN.
//  Not defined: no check, swap always happens, cfg_err tied 0, out-of-range selects route zero.
// TESTING
//  1 MOD_N=4,SLOT_N=4,REG_EVERY=1: module2 wren=1,waddr=0x10,wdata=0xAB, slot1 sel=2 -> ram_inputs[1] same values after 2 cycles.
//  2 Broadcast: slots 0..3 all sel module 3, streaming waddr 0..15 -> all slots get identical stream, LAT_F delay, no gaps.
//  3 Return: module0 sel slot3, ram_outputs[3]=0xDEAD -> module_inputs[0]=0xDEAD after LAT_R=2; others unaffected.
//  4 Commit: cfg_wr remap then cfg_commit with RAM_LAT=2 -> cfg_busy high 6+1 cycles, no wren=1 at ram_inputs during window,
//    new routing from first post-SWAP request; second cfg_commit mid-DRAIN ignored.
//  5 MOD_N=3: slot sel=3 -> ram_inputs all-zero; with BUF_INTC_CFG_CHECK_EN commit refused, cfg_err=1, old routing kept.
//  6 rstn low during DRAIN -> all outputs 0, cfg_busy=0 next edge-free cycle, selects back to 0.

Source files
------------

// File: rtl/buffer_interconnect_v6.sv
// ----------------------------------------------------------------------------------------------
// buffer_interconnect_v6
//
// Pipelined crossbar between FHE compute modules and buffer-RAM slots.
//   Forward path : module request {raddr, waddr, wdata, wren} -> slot, through a binary mux tree
//                  per slot (LM levels, LAT_F cycles).
//   Return path  : slot read data -> module, through a binary mux tree per module (LS levels,
//                  LAT_R cycles).
// A pipeline register sits after every REG_EVERY mux levels and always after the last level.
// Each level carries the select bits of the request it holds, so a routing change never mixes
// old and new selects inside one transfer.
//
// Routing config is double-buffered: cfg_wr loads the shadow selects, cfg_commit starts a drain
// of DRAIN = LAT_F + RAM_LAT + LAT_R cycles (writes masked at the tree inputs), followed by a
// one-cycle swap of shadow into active. cfg_busy / intc_stall are high for drain plus swap.
//
// Optional feature macro: BUF_INTC_CFG_CHECK_EN
//   defined   : a swap whose selects are out of range is refused and cfg_err is set (sticky).
//   undefined : no check, swap always happens, cfg_err tied low.
//
// Ports
//   clk             in   clock
//   rstn            in   asynchronous active-low reset
//   module_outputs  in   [MOD_N][REQ_W]  per-module request, packed {raddr, waddr, wdata, wren}
//   ram_inputs      out  [SLOT_N][REQ_W] per-slot routed request (same packing)
//   ram_outputs     in   [SLOT_N][DW]    per-slot read data
//   module_inputs   out  [MOD_N][DW]     per-module routed read data
//   cfg_module_sel  in   [SLOT_N][LM]    shadow: source module for each slot
//   cfg_slot_sel    in   [MOD_N][LS]     shadow: source slot for each module
//   cfg_wr          in   load both cfg_* vectors into the shadow registers
//   cfg_commit      in   request shadow -> active swap (ignored while busy)
//   cfg_busy        out  high during drain and swap
//   intc_stall      out  copy of cfg_busy; modules must hold their requests
//   cfg_err         out  sticky config error
// ----------------------------------------------------------------------------------------------
module buffer_interconnect_v6 #(
    parameter int unsigned SLOT_N    = 4,
    parameter int unsigned MOD_N     = 4,
    parameter int unsigned DW        = 32,
    parameter int unsigned AW        = 32,
    parameter int unsigned REG_EVERY = 1,
    parameter int unsigned RAM_LAT   = 2,
    localparam int unsigned LM       = $clog2(MOD_N),
    localparam int unsigned LS       = $clog2(SLOT_N),
    localparam int unsigned REQ_W    = 2 * AW + DW + 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [MOD_N-1:0][REQ_W-1:0]    module_outputs,
    output logic [SLOT_N-1:0][REQ_W-1:0]   ram_inputs,
    input  logic [SLOT_N-1:0][DW-1:0]      ram_outputs,
    output logic [MOD_N-1:0][DW-1:0]       module_inputs,
    input  logic [SLOT_N-1:0][LM-1:0]      cfg_module_sel,
    input  logic [MOD_N-1:0][LS-1:0]       cfg_slot_sel,
    input  logic                           cfg_wr,
    input  logic                           cfg_commit,
    output logic                           cfg_busy,
    output logic                           intc_stall,
    output logic                           cfg_err
);

    localparam int unsigned NPM   = 1 << LM;  // forward tree legs incl. zero padding
    localparam int unsigned NPS   = 1 << LS;  // return tree legs incl. zero padding
    localparam int unsigned LAT_F = (LM + REG_EVERY - 1) / REG_EVERY;
    localparam int unsigned LAT_R = (LS + REG_EVERY - 1) / REG_EVERY;
    localparam int unsigned DRAIN = LAT_F + RAM_LAT + LAT_R;
    localparam int unsigned CW    = $clog2(DRAIN + 1);
    localparam logic [CW-1:0] DRAIN_INIT = CW'(DRAIN - 1);

    // ------------------------------------------------------------------------------------------
    // Config FSM
    // ------------------------------------------------------------------------------------------
    typedef enum logic [1:0] {StRun, StDrain, StSwap} state_e;

    state_e                    state_q;
    logic [CW-1:0]             cnt_q;
    logic                      busy_q;
    logic [SLOT_N-1:0][LM-1:0] shd_msel_q;
    logic [SLOT_N-1:0][LM-1:0] act_msel_q;
    logic [MOD_N-1:0][LS-1:0]  shd_ssel_q;
    logic [MOD_N-1:0][LS-1:0]  act_ssel_q;

    // Value copied in the swap cycle: a cfg_wr in that very cycle wins over the shadow.
    logic [SLOT_N-1:0][LM-1:0] swap_msel;
    logic [MOD_N-1:0][LS-1:0]  swap_ssel;
    logic                      swap_ok;

    always_comb begin
        swap_msel = cfg_wr ? cfg_module_sel : shd_msel_q;
        swap_ssel = cfg_wr ? cfg_slot_sel : shd_ssel_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StRun;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            shd_msel_q <= '0;
            shd_ssel_q <= '0;
            act_msel_q <= '0;
            act_ssel_q <= '0;
        end else begin
            if (cfg_wr) begin
                shd_msel_q <= cfg_module_sel;
                shd_ssel_q <= cfg_slot_sel;
            end
            unique case (state_q)
                StRun: begin
                    if (cfg_commit) begin
                        state_q <= StDrain;
                        cnt_q   <= DRAIN_INIT;
                        busy_q  <= 1'b1;
                    end
                end
                StDrain: begin
                    if (cnt_q == '0) begin
                        state_q <= StSwap;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                StSwap: begin
                    if (swap_ok) begin
                        act_msel_q <= swap_msel;
                        act_ssel_q <= swap_ssel;
                    end
                    state_q <= StRun;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StRun;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_busy   = busy_q;
    assign intc_stall = busy_q;

`ifdef BUF_INTC_CFG_CHECK_EN
    logic err_q;

    always_comb begin
        swap_ok = 1'b1;
        for (int s = 0; s < SLOT_N; s++) begin
            if (32'(swap_msel[s]) >= MOD_N) swap_ok = 1'b0;
        end
        for (int m = 0; m < MOD_N; m++) begin
            if (32'(swap_ssel[m]) >= SLOT_N) swap_ok = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (state_q == StSwap && !swap_ok) begin
            err_q <= 1'b1;
        end
    end

    assign cfg_err = err_q;
`else
    assign swap_ok = 1'b1;
    assign cfg_err = 1'b0;
`endif

    // ------------------------------------------------------------------------------------------
    // Tree inputs, padded to a power of two with all-zero legs
    // ------------------------------------------------------------------------------------------
    logic [NPM-1:0][REQ_W-1:0] req_pad;
    logic [NPS-1:0][DW-1:0]    rd_pad;

    always_comb begin
        req_pad = '0;
        for (int m = 0; m < MOD_N; m++) begin
            req_pad[m]    = module_outputs[m];
            // Writes are blocked while draining so nothing lands under a half-switched route.
            req_pad[m][0] = module_outputs[m][0] & ~busy_q;
        end
    end

    always_comb begin
        rd_pad = '0;
        for (int s = 0; s < SLOT_N; s++) begin
            rd_pad[s] = ram_outputs[s];
        end
    end

    // ------------------------------------------------------------------------------------------
    // Forward trees: one per slot. Level l holds NPM>>l nodes; sel is shifted right at every
    // level so bit 0 always steers the next mux.
    // ------------------------------------------------------------------------------------------
    for (genvar s = 0; s < SLOT_N; s++) begin : g_fwd
        for (genvar l = 0; l <= LM; l++) begin : g_lvl
            localparam int NN = int'(NPM >> l);
            logic [REQ_W-1:0] node [NN];
            logic [LM-1:0]    sel;

            if (l == 0) begin : g_leaf
                always_comb begin
                    sel = act_msel_q[s];
                    for (int i = 0; i < NN; i++) node[i] = req_pad[i];
                end
            end else begin : g_stage
                logic [REQ_W-1:0] mux [NN];

                always_comb begin
                    for (int i = 0; i < NN; i++) begin
                        mux[i] = g_lvl[l-1].sel[0] ? g_lvl[l-1].node[2*i+1]
                                                   : g_lvl[l-1].node[2*i];
                    end
                end

                if ((l % REG_EVERY) == 0 || l == LM) begin : g_reg
                    always_ff @(posedge clk or negedge rstn) begin
                        if (!rstn) begin
                            sel <= '0;
                            for (int i = 0; i < NN; i++) node[i] <= '0;
                        end else begin
                            sel <= g_lvl[l-1].sel >> 1;
                            for (int i = 0; i < NN; i++) node[i] <= mux[i];
                        end
                    end
                end else begin : g_comb
                    always_comb begin
                        sel = g_lvl[l-1].sel >> 1;
                        for (int i = 0; i < NN; i++) node[i] = mux[i];
                    end
                end
            end
        end

        // All select bits are consumed by the time the root is reached.
        logic unused_fwd_sel;
        assign unused_fwd_sel = ^g_lvl[LM].sel;
        assign ram_inputs[s]  = g_lvl[LM].node[0];
    end

    // ------------------------------------------------------------------------------------------
    // Return trees: one per module, same structure over the slot read data.
    // ------------------------------------------------------------------------------------------
    for (genvar m = 0; m < MOD_N; m++) begin : g_ret
        for (genvar l = 0; l <= LS; l++) begin : g_lvl
            localparam int NN = int'(NPS >> l);
            logic [DW-1:0] node [NN];
            logic [LS-1:0] sel;

            if (l == 0) begin : g_leaf
                always_comb begin
                    sel = act_ssel_q[m];
                    for (int i = 0; i < NN; i++) node[i] = rd_pad[i];
                end
            end else begin : g_stage
                logic [DW-1:0] mux [NN];

                always_comb begin
                    for (int i = 0; i < NN; i++) begin
                        mux[i] = g_lvl[l-1].sel[0] ? g_lvl[l-1].node[2*i+1]
                                                   : g_lvl[l-1].node[2*i];
                    end
                end

                if ((l % REG_EVERY) == 0 || l == LS) begin : g_reg
                    always_ff @(posedge clk or negedge rstn) begin
                        if (!rstn) begin
                            sel <= '0;
                            for (int i = 0; i < NN; i++) node[i] <= '0;
                        end else begin
                            sel <= g_lvl[l-1].sel >> 1;
                            for (int i = 0; i < NN; i++) node[i] <= mux[i];
                        end
                    end
                end else begin : g_comb
                    always_comb begin
                        sel = g_lvl[l-1].sel >> 1;
                        for (int i = 0; i < NN; i++) node[i] = mux[i];
                    end
                end
            end
        end

        logic unused_ret_sel;
        assign unused_ret_sel   = ^g_lvl[LS].sel;
        assign module_inputs[m] = g_lvl[LS].node[0];
    end

endmodule

// File: tb/tb_buffer_interconnect_v6.sv
// Directed bench for buffer_interconnect_v6: a 4x4 instance for routing, broadcast, return path,
// commit/drain and reset, plus a 3-module instance for out-of-range selects.
module tb_buffer_interconnect_v6;

    localparam int unsigned DWT = 16;
    localparam int unsigned AWT = 8;
    localparam int unsigned RW  = 2 * AWT + DWT + 1;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    // 4 modules x 4 slots
    logic [3:0][RW-1:0]  mo;
    logic [3:0][RW-1:0]  ri;
    logic [3:0][DWT-1:0] ro;
    logic [3:0][DWT-1:0] mi;
    logic [3:0][1:0]     cms;
    logic [3:0][1:0]     css;
    logic                cfg_wr, cfg_commit, busy, stall, err;

    // 3 modules x 2 slots
    logic [2:0][RW-1:0]  mo_b;
    logic [1:0][RW-1:0]  ri_b;
    logic [1:0][DWT-1:0] ro_b;
    logic [2:0][DWT-1:0] mi_b;
    logic [1:0][1:0]     cms_b;
    logic [2:0][0:0]     css_b;
    logic                cfg_wr_b, cfg_commit_b, busy_b, stall_b, err_b;

    int checks = 0;
    int errors = 0;

    buffer_interconnect_v6 #(
        .SLOT_N(4), .MOD_N(4), .DW(DWT), .AW(AWT), .REG_EVERY(1), .RAM_LAT(2)
    ) u_dut (
        .clk            (clk),
        .rstn           (rstn),
        .module_outputs (mo),
        .ram_inputs     (ri),
        .ram_outputs    (ro),
        .module_inputs  (mi),
        .cfg_module_sel (cms),
        .cfg_slot_sel   (css),
        .cfg_wr         (cfg_wr),
        .cfg_commit     (cfg_commit),
        .cfg_busy       (busy),
        .intc_stall     (stall),
        .cfg_err        (err)
    );

    buffer_interconnect_v6 #(
        .SLOT_N(2), .MOD_N(3), .DW(DWT), .AW(AWT), .REG_EVERY(1), .RAM_LAT(2)
    ) u_dut_b (
        .clk            (clk),
        .rstn           (rstn),
        .module_outputs (mo_b),
        .ram_inputs     (ri_b),
        .ram_outputs    (ro_b),
        .module_inputs  (mi_b),
        .cfg_module_sel (cms_b),
        .cfg_slot_sel   (css_b),
        .cfg_wr         (cfg_wr_b),
        .cfg_commit     (cfg_commit_b),
        .cfg_busy       (busy_b),
        .intc_stall     (stall_b),
        .cfg_err        (err_b)
    );

    function automatic logic [RW-1:0] req(input logic [7:0] ra, input logic [7:0] wa,
                                          input logic [15:0] wd, input logic we);
        return {ra, wa, wd, we};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write + commit in one cycle, then wait (bounded) for the busy window to close.
    task automatic apply_cfg(input logic [3:0][1:0] m_sel, input logic [3:0][1:0] s_sel);
        int n;
        cms        = m_sel;
        css        = s_sel;
        cfg_wr     = 1'b1;
        cfg_commit = 1'b1;
        tick();
        cfg_wr     = 1'b0;
        cfg_commit = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL cfg_timeout: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        mo   = {4{req(8'hFF, 8'hEE, 16'hDDDD, 1'b1)}};
        ro   = {4{16'hCCCC}};
        mo_b = {3{req(8'h11, 8'h22, 16'h3333, 1'b1)}};
        ro_b = {2{16'h4444}};
        repeat (3) tick();
        checks++; if (ri !== '0) begin errors++; $display("FAIL rst_ri: %h req 0", ri); end
        checks++; if (mi !== '0) begin errors++; $display("FAIL rst_mi: %h req 0", mi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: %b req 0", busy); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: %b req 0", stall); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: %b req 0", err); end
        checks++; if (ri_b !== '0) begin errors++; $display("FAIL rst_ri_b: %h req 0", ri_b); end
        mo   = '0;
        ro   = '0;
        mo_b = '0;
        ro_b = '0;
        #4 rstn = 1'b1;
        tick();
    endtask

    task automatic test_forward();
        logic [3:0][1:0] m_sel;
        logic [RW-1:0]   exp;
        m_sel    = '0;
        m_sel[1] = 2'd2;
        apply_cfg(m_sel, '0);
        exp   = req(8'h00, 8'h10, 16'h00AB, 1'b1);
        mo[2] = exp;
        tick();
        checks++;
        if (ri[1] !== '0) begin
            errors++; $display("FAIL fwd_lat1: ri[1]=%h required 0", ri[1]);
        end
        tick();
        checks++;
        if (ri[1] !== exp) begin
            errors++; $display("FAIL fwd_lat2: ri[1]=%h required %h", ri[1], exp);
        end
        checks++;
        if (ri[0] !== '0) begin
            errors++; $display("FAIL fwd_other: ri[0]=%h required 0", ri[0]);
        end
        mo = '0;
        repeat (2) tick();
    endtask

    task automatic test_broadcast();
        logic [RW-1:0] exp;
        apply_cfg({4{2'd3}}, '0);
        for (int i = 0; i <= 16; i++) begin
            mo[3] = (i < 16) ? req(8'(i), 8'(i), 16'(i * 257), 1'b1) : '0;
            tick();
            if (i >= 1) begin
                exp = req(8'(i - 1), 8'(i - 1), 16'((i - 1) * 257), 1'b1);
                for (int s = 0; s < 4; s++) begin
                    checks++;
                    if (ri[s] !== exp) begin
                        errors++;
                        $display("FAIL bcast[%0d] slot%0d: %h required %h", i - 1, s, ri[s], exp);
                    end
                end
            end
        end
        mo = '0;
        repeat (2) tick();
    endtask

    task automatic test_return();
        logic [3:0][1:0] s_sel;
        s_sel = {2'd1, 2'd1, 2'd1, 2'd3};
        apply_cfg({4{2'd3}}, s_sel);
        ro = {16'hDEAD, 16'h2222, 16'h1111, 16'h0F0F};
        tick();
        checks++;
        if (mi[0] !== '0) begin
            errors++; $display("FAIL ret_lat1: mi[0]=%h required 0", mi[0]);
        end
        tick();
        checks++;
        if (mi[0] !== 16'hDEAD) begin
            errors++; $display("FAIL ret_lat2: mi[0]=%h required dead", mi[0]);
        end
        for (int m = 1; m < 4; m++) begin
            checks++;
            if (mi[m] !== 16'h1111) begin
                errors++; $display("FAIL ret_other%0d: %h required 1111", m, mi[m]);
            end
        end
    endtask

    task automatic test_commit();
        int   n;
        logic wren_seen;
        logic [RW-1:0] r1, r2, r3;
        r1 = req(8'h11, 8'h12, 16'h1111, 1'b1);
        r2 = req(8'h21, 8'h22, 16'h5A5A, 1'b1);
        r3 = req(8'h31, 8'h32, 16'h3333, 1'b1);
        // Active: all slots <- module 3. New: slot0<-2, slot1<-1, slot2<-0, slot3<-3.
        cms        = {2'd3, 2'd0, 2'd1, 2'd2};
        cfg_wr     = 1'b1;
        cfg_commit = 1'b1;
        tick();
        cfg_wr     = 1'b0;
        cfg_commit = 1'b0;
        checks++;
        if (busy !== 1'b1 || stall !== 1'b1) begin
            errors++; $display("FAIL commit_busy_rise: busy=%b stall=%b required 1 1", busy, stall);
        end
        mo[1] = r1;
        mo[2] = r2;
        mo[3] = r3;
        wren_seen = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (ri[0][0] | ri[1][0] | ri[2][0] | ri[3][0]) wren_seen = 1'b1;
            if (n == 3) begin
                // Held request reaches the slot under the old route, address intact, write off.
                checks++;
                if (ri[0] !== req(8'h31, 8'h32, 16'h3333, 1'b0)) begin
                    errors++; $display("FAIL drain_raddr: ri[0]=%h required %h", ri[0],
                                       req(8'h31, 8'h32, 16'h3333, 1'b0));
                end
            end
            cfg_commit = (n == 3);  // second commit mid-drain must be ignored
            tick();
        end
        cfg_commit = 1'b0;
        checks++;
        if (n !== 7) begin
            errors++; $display("FAIL busy_len: %0d cycles required 7", n);
        end
        checks++;
        if (wren_seen !== 1'b0) begin
            errors++; $display("FAIL drain_wren: wren seen=%b required 0", wren_seen);
        end
        tick();
        checks++;
        if (ri[0] !== req(8'h31, 8'h32, 16'h3333, 1'b0)) begin
            errors++; $display("FAIL swap_cycle: ri[0]=%h required %h", ri[0],
                               req(8'h31, 8'h32, 16'h3333, 1'b0));
        end
        tick();
        checks++;
        if (ri[0] !== r2) begin
            errors++; $display("FAIL new_route0: ri[0]=%h required %h", ri[0], r2);
        end
        checks++;
        if (ri[1] !== r1) begin
            errors++; $display("FAIL new_route1: ri[1]=%h required %h", ri[1], r1);
        end
        checks++;
        if (ri[2] !== '0) begin
            errors++; $display("FAIL new_route2: ri[2]=%h required 0", ri[2]);
        end
        checks++;
        if (ri[3] !== r3) begin
            errors++; $display("FAIL new_route3: ri[3]=%h required %h", ri[3], r3);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL commit_not_queued: busy=%b required 0", busy);
        end
    endtask

    task automatic test_range();
        int n;
        logic [RW-1:0] exp0, exp1;
        logic          exp_err;
        mo_b[0] = req(8'h01, 8'h02, 16'h0A0A, 1'b1);
        mo_b[1] = req(8'h03, 8'h04, 16'h0B0B, 1'b1);
        mo_b[2] = req(8'h05, 8'h06, 16'h0C0C, 1'b1);
        ro_b    = {16'h8888, 16'h7777};
        cms_b   = {2'd1, 2'd3};  // slot0 <- nonexistent module 3
        css_b   = '0;
        cfg_wr_b     = 1'b1;
        cfg_commit_b = 1'b1;
        tick();
        cfg_wr_b     = 1'b0;
        cfg_commit_b = 1'b0;
        n = 0;
        while (busy_b && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 6) begin
            errors++; $display("FAIL b_busy_len: %0d cycles required 6", n);
        end
        repeat (2) tick();
`ifdef BUF_INTC_CFG_CHECK_EN
        exp0    = mo_b[0];
        exp1    = mo_b[0];
        exp_err = 1'b1;
`else
        exp0    = '0;
        exp1    = mo_b[1];
        exp_err = 1'b0;
`endif
        checks++;
        if (ri_b[0] !== exp0) begin
            errors++; $display("FAIL range_slot0: %h required %h", ri_b[0], exp0);
        end
        checks++;
        if (ri_b[1] !== exp1) begin
            errors++; $display("FAIL range_slot1: %h required %h", ri_b[1], exp1);
        end
        checks++;
        if (err_b !== exp_err) begin
            errors++; $display("FAIL range_err: %b required %b", err_b, exp_err);
        end
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (mi_b[m] !== 16'h7777) begin
                errors++; $display("FAIL b_ret%0d: %h required 7777", m, mi_b[m]);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [RW-1:0] r0;
        cms        = {4{2'd1}};
        cfg_wr     = 1'b1;
        cfg_commit = 1'b1;
        tick();
        cfg_wr     = 1'b0;
        cfg_commit = 1'b0;
        tick();
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL rst_drain_busy: busy=%b stall=%b required 0 0", busy, stall);
        end
        checks++;
        if (ri !== '0) begin errors++; $display("FAIL rst_drain_ri: %h required 0", ri); end
        checks++;
        if (mi !== '0) begin errors++; $display("FAIL rst_drain_mi: %h required 0", mi); end
        r0    = req(8'h41, 8'h42, 16'h4444, 1'b1);
        mo    = '0;
        mo[0] = r0;
        ro    = '0;
        ro[0] = 16'hBEEF;
        #1 rstn = 1'b1;
        repeat (2) tick();
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (ri[s] !== r0) begin
                errors++; $display("FAIL rst_sel_fwd%0d: %h required %h", s, ri[s], r0);
            end
            checks++;
            if (mi[s] !== 16'hBEEF) begin
                errors++; $display("FAIL rst_sel_ret%0d: %h required beef", s, mi[s]);
            end
        end
        repeat (8) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rst_commit_lost: busy=%b required 0", busy);
        end
    endtask

    initial begin
        rstn         = 1'b0;
        mo           = '0;
        ro           = '0;
        cms          = '0;
        css          = '0;
        cfg_wr       = 1'b0;
        cfg_commit   = 1'b0;
        mo_b         = '0;
        ro_b         = '0;
        cms_b        = '0;
        css_b        = '0;
        cfg_wr_b     = 1'b0;
        cfg_commit_b = 1'b0;
        test_reset();
        test_forward();
        test_broadcast();
        test_return();
        test_commit();
        test_range();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
